// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic               is_div, neg_q, neg_r;
   logic               idle_like, accept, reg_wr_ok;
   logic               sgn_a, sgn_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] acc_nx, prod_fix;
   logic [WIDTH-1:0]   hi_res, lo_res;

   assign idle_like = (state == IDLE) || (state == DONE);
   assign accept    = start && idle_like;
   assign reg_wr_ok = idle_like && !start;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == '0) state_nx = FIXUP;
         FIXUP:   state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == FIXUP);
      done = (state == DONE);
   end

   // op[0] set means unsigned; signed operands enter the datapath as magnitudes
   always_comb begin
      sgn_a = ~op[0] & a[WIDTH-1];
      sgn_b = ~op[0] & b[WIDTH-1];
      mag_a = sgn_a ? -a : a;
      mag_b = sgn_b ? -b : b;
   end

   // acc holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      div_ge  = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opb};
      div_rem = acc[2*WIDTH-2:WIDTH-1] - opb;
      if (!is_div)
         acc_nx = {mul_sum, acc[WIDTH-1:1]};
      else if (div_ge)
         acc_nx = {div_rem, acc[WIDTH-2:0], 1'b1};
      else
         acc_nx = {acc[2*WIDTH-2:0], 1'b0};
   end

   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      if (is_div) begin
         lo_res = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         hi_res = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end else begin
         lo_res = prod_fix[WIDTH-1:0];
         hi_res = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   // quotient of a divide by zero is left un-negated so it reads as all ones
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         acc    <= '0;
         opb    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (accept) begin
         cnt    <= CW'(WIDTH-1);
         acc    <= {{WIDTH{1'b0}}, mag_a};
         opb    <= mag_b;
         is_div <= op[1];
         neg_q  <= (sgn_a ^ sgn_b) && !(op[1] && (b == '0));
         neg_r  <= sgn_a & op[1];
      end else if (state == RUN) begin
         cnt <= cnt - CW'(1);
         acc <= acc_nx;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hi <= '0;
         lo <= '0;
      end else if (state == FIXUP) begin
         hi <= hi_res;
         lo <= lo_res;
      end else if (reg_wr_ok) begin
         if (hi_wr) hi <= wdata;
         if (lo_wr) lo <= wdata;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;
   logic        clock;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        hi_wr, lo_wr;
   logic [31:0] wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // reference result {hi, lo} from plain integer arithmetic
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int     sx, sy, q, m;
      longint sp;
      logic [63:0] r;
      sx = int'(x);
      sy = int'(y);
      r = '0;
      case (o)
         2'b00: begin
            sp = longint'(sx) * longint'(sy);
            r = 64'(sp);
         end
         2'b01: r = {32'b0, x} * {32'b0, y};
         2'b10: begin
            if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, x};
            else begin
               q = sx / sy;
               m = sx % sy;
               r = {32'(m), 32'(q)};
            end
         end
         default: begin
            if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
            else r = {x % y, x / y};
         end
      endcase
      return r;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // issue one op from IDLE/DONE; returns edges until done and busy cycles seen
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_n);
      start = 1'b1; op = o; a = x; b = y;
      step();
      start = 1'b0;
      a = $urandom; b = $urandom;
      lat = 0;
      busy_n = 0;
      while (!done && lat < 100) begin
         if (busy) busy_n++;
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
      step(); step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
      reset_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
      logic [31:0] xs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'h7, 32'hFFFF_FFF9};
      logic [31:0] ys  [6] = '{32'h5, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h0};
      logic [63:0] exp [6] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFD,
                               64'h0000_0000_8000_0000, 64'h0000_0007_FFFF_FFFF, 64'hFFFF_FFF9_FFFF_FFFF};
      int lat, bn;
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], xs[i], ys[i], lat, bn);
         checks++; if (lat !== 33) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=33", i, lat); end
         checks++; if (bn !== 33) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, bn); end
         checks++; if ({hi, lo} !== exp[i]) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, {hi, lo}, exp[i]); end
         step();
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dir%0d_done_width got=%b%b exp=00", i, done, busy); end
      end
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] x, y;
      logic [63:0] e;
      int lat, bn;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom; y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'h0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: begin x = 32'($urandom_range(0, 300)) - 32'd150; y = 32'($urandom_range(0, 20)) - 32'd10; end
            3: y = 32'($urandom_range(1, 9));
            default: ;
         endcase
         e = model(o, x, y);
         do_op(o, x, y, lat, bn);
         checks++; if (lat !== 33) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=33", i, lat); end
         checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, x, y, {hi, lo}, e); end
         if ($urandom_range(0, 1) == 0) step();
      end
      step();
   endtask

   task automatic test_ignore();
      logic [63:0] e;
      int lat;
      e = model(2'b00, 32'hFFFF_FFFD, 32'h5);
      start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFD; b = 32'h5;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      start = 1'b1; op = 2'b11; a = 32'h99; b = 32'h3;
      hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h1234;
      step(); step();
      start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      lat = 7;
      while (!done && lat < 100) begin step(); lat++; end
      checks++; if (lat !== 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
      checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL ignore_result got=%h exp=%h", {hi, lo}, e); end
      step();
      hi_wr = 1'b1; wdata = 32'h1234;
      step();
      hi_wr = 1'b0;
      checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mthi_idle got=%h exp=00001234", hi); end
      checks++; if (lo !== e[31:0]) begin failures++; $display("FAIL mthi_keeps_lo got=%h exp=%h", lo, e[31:0]); end
      lo_wr = 1'b1; wdata = 32'h5678;
      step();
      lo_wr = 1'b0;
      checks++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin failures++; $display("FAIL mtlo_idle got=%h exp=0000123400005678", {hi, lo}); end
      start = 1'b1; op = 2'b01; a = 32'h2; b = 32'h3;
      hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hDEAD;
      step();
      start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      checks++; if ({hi, lo} !== 64'h0000_1234_0000_5678) begin failures++; $display("FAIL wr_dropped_on_accept got=%h exp=0000123400005678", {hi, lo}); end
      lat = 1;
      while (!done && lat < 100) begin step(); lat++; end
      checks++; if ({hi, lo} !== 64'h6) begin failures++; $display("FAIL accept_result got=%h exp=6", {hi, lo}); end
      step();
   endtask

   task automatic test_reset_mid();
      int seen;
      start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'h3;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) step();
      #2 reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
      checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL midreset_hilo got=%h exp=0", {hi, lo}); end
      step();
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done || busy) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] e1, e2;
      int lat, bn;
      e1 = model(2'b10, 32'h0000_0064, 32'hFFFF_FFF9);
      e2 = model(2'b00, 32'h8000_0000, 32'h8000_0000);
      do_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, lat, bn);
      checks++; if ({hi, lo} !== e1) begin failures++; $display("FAIL b2b_first got=%h exp=%h", {hi, lo}, e1); end
      do_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bn);
      checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
      checks++; if ({hi, lo} !== e2) begin failures++; $display("FAIL b2b_second got=%h exp=%h", {hi, lo}, e2); end
      step();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
